// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and burst sequencer sharing one UART transmit-FIFO write port.
// Each grant emits an optional header byte (0xA0 | id) followed by up to MAX_BURST payload bytes.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int NBITS     = 8,
  parameter int MAX_BURST = 16,
  parameter int HDR_EN    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NBITS-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       ack,
  input  logic                  tx_full,
  output logic                  twr_en,
  output logic [NBITS-1:0]      twr_data,
  output logic                  busy,
  output logic [3:0]            gnt_id
);

  localparam int IDW   = $clog2(NREQ);
  localparam int SW    = IDW + 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [SW-1:0]    NREQ_S   = SW'(NREQ);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam logic [NBITS-1:0] HDR_BASE = NBITS'(8'hA0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [CNT_W-1:0] count;

  logic [NBITS-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*NBITS +: NBITS];
  end

  // Rotate requests so bit 0 is the highest-priority requester (rr_ptr).
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              pick_valid;
  logic [SW-1:0]     pick_sum;
  logic [IDW-1:0]    pick_id;

  assign req_dbl = {req, req};
  assign req_rot = NREQ'(req_dbl >> rr_ptr);

  // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    pick_valid = 1'b0;
    pick_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_valid && req_rot[k]) begin
        pick_valid = 1'b1;
        pick_sum   = SW'(k) + {1'b0, rr_ptr};
      end
    end
    pick_id = (pick_sum >= NREQ_S) ? IDW'(pick_sum - NREQ_S) : IDW'(pick_sum);
  end

  logic             g_req;
  logic             g_last;
  logic [NBITS-1:0] g_data;
  logic             burst_end;
  logic [IDW-1:0]   next_ptr;

  assign g_req     = req[gnt_idx];
  assign g_last    = req_last[gnt_idx];
  assign g_data    = data_arr[gnt_idx];
  assign burst_end = g_last || (count == LAST_CNT);
  assign next_ptr  = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

  assign gnt_id = 4'(gnt_idx);
  assign busy   = (state != IDLE);

  // Write port and acks are combinational so a byte is consumed in the same cycle it is offered.
  always_comb begin
    twr_en   = 1'b0;
    twr_data = '0;
    ack      = '0;
    unique case (state)
      HDR: begin
        twr_en   = !tx_full;
        twr_data = HDR_BASE | NBITS'(gnt_id);
      end
      DATA: begin
        if (g_req && !tx_full) begin
          twr_en       = 1'b1;
          twr_data     = g_data;
          ack[gnt_idx] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      gnt_idx <= '0;
      count   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt_idx <= pick_id;
            count   <= '0;
            state   <= (HDR_EN != 0) ? HDR : DATA;
          end
        end
        HDR: begin
          if (!tx_full) state <= DATA;
        end
        DATA: begin
          if (!g_req) begin
            state  <= IDLE;
            rr_ptr <= next_ptr;
          end else if (!tx_full) begin
            count <= count + 1'b1;
            if (burst_end) begin
              state  <= IDLE;
              rr_ptr <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (!reset)
    !(twr_en && tx_full));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(ack));
  a_ack_with_write: assert property (@(posedge clk) disable iff (!reset)
    (|ack) |-> (twr_en && state == DATA));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter, checked cycle by cycle against a
// rule-level reference model plus literal FIFO byte sequences for the directed scenarios.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int NBITS     = 8;
  localparam int MAX_BURST = 4;
  localparam int HDR_EN    = 1;
  localparam int DEPTH     = 64;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*NBITS-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       ack;
  logic                  tx_full;
  logic                  twr_en;
  logic [NBITS-1:0]      twr_data;
  logic                  busy;
  logic [3:0]            gnt_id;

  uart_tx_arbiter #(
    .NREQ(NREQ), .NBITS(NBITS), .MAX_BURST(MAX_BURST), .HDR_EN(HDR_EN)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .tx_full(tx_full), .twr_en(twr_en), .twr_data(twr_data),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester byte sources
  logic [7:0] bdata [NREQ][DEPTH];
  logic       blast [NREQ][DEPTH];
  int head [NREQ];
  int tail [NREQ];
  int abandon_at [NREQ];
  int ack_cnt [NREQ];
  int dut_ack_cnt [NREQ];

  task automatic push(input int i, input logic [7:0] d, input logic l);
    bdata[i][tail[i]] = d;
    blast[i][tail[i]] = l;
    tail[i]++;
  endtask

  task automatic flush(input int i);
    head[i] = 0;
    tail[i] = 0;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req[i]                 = head[i] < tail[i];
      req_data[i*NBITS +: NBITS] = 8'h00;
      req_last[i]            = 1'b0;
      if (req[i]) begin
        req_data[i*NBITS +: NBITS] = bdata[i][head[i]];
        req_last[i]                = blast[i][head[i]];
      end
    end
  endtask

  // Reference model: arbitration and burst rules in plain integers
  bit m_busy, m_hdr;
  int m_owner, m_sent, m_ptr, m_gnt;
  bit         e_en;
  logic [7:0] e_data;
  logic [NREQ-1:0] e_ack;

  logic [7:0] wr_log [$];
  logic [7:0] exp_q [$];
  int quiet_viol;

  task automatic model_reset();
    m_busy = 0; m_hdr = 0; m_owner = 0; m_sent = 0; m_ptr = 0; m_gnt = 0;
  endtask

  task automatic model_expect();
    e_en = 0; e_data = 8'h00; e_ack = '0;
    if (m_busy) begin
      if (m_hdr) begin
        e_en   = !tx_full;
        e_data = 8'hA0 | 8'(m_owner);
      end else if (req[m_owner] && !tx_full) begin
        e_en           = 1;
        e_data         = req_data[m_owner*NBITS +: NBITS];
        e_ack[m_owner] = 1'b1;
      end
    end
  endtask

  task automatic model_commit();
    bit found;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (!found && req[idx]) begin
          found = 1; m_busy = 1; m_owner = idx; m_gnt = idx; m_sent = 0; m_hdr = (HDR_EN != 0);
        end
      end
    end else if (m_hdr) begin
      if (e_en) m_hdr = 0;
    end else if (!req[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % NREQ;
    end else if (e_en) begin
      m_sent++;
      if (req_last[m_owner] || m_sent == MAX_BURST) begin
        m_busy = 0; m_ptr = (m_owner + 1) % NREQ;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (e_ack[i]) begin
        head[i]++;
        ack_cnt[i]++;
        if (head[i] == tail[i] || ack_cnt[i] == abandon_at[i]) flush(i);
      end
    end
  endtask

  // One clock: drive after the edge, compare at the falling edge, advance model at the rising edge.
  task automatic step();
    drive_inputs();
    @(negedge clk);
    model_expect();
    check("twr_en", twr_en, e_en);
    check("ack", ack, e_ack);
    check("busy", busy, m_busy);
    check("gnt_id", gnt_id, m_gnt);
    if (e_en) check("twr_data", twr_data, e_data);
    if (twr_en) wr_log.push_back(twr_data);
    if (tx_full && (twr_en || |ack)) quiet_viol++;
    for (int i = 0; i < NREQ; i++) dut_ack_cnt[i] += int'(ack[i]);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_len"}, wr_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < wr_log.size()) check(tag, wr_log[i], exp_q[i]);
    wr_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      flush(i); abandon_at[i] = -1; ack_cnt[i] = 0; dut_ack_cnt[i] = 0;
    end
    drive_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    tx_full = 1'b0;
    req = '0; req_data = '0; req_last = '0;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      flush(i); abandon_at[i] = -1; ack_cnt[i] = 0; dut_ack_cnt[i] = 0;
    end
    model_reset();
    #3;
    check("rst_twr_en", twr_en, 1'b0);
    check("rst_ack", ack, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_twr_data", twr_data, 8'h00);
    check("rst_gnt_id", gnt_id, 4'h0);
    do_reset();

    // Single burst from requester 2, then rr_ptr=3 favours requester 3 over 0
    push(2, 8'h11, 0); push(2, 8'h22, 0); push(2, 8'h33, 1);
    run(8);
    exp_q = '{8'hA2, 8'h11, 8'h22, 8'h33};
    compare_log("single");
    check("single_acks", dut_ack_cnt[2], 3);
    push(0, 8'h55, 1); push(3, 8'h66, 1);
    run(10);
    exp_q = '{8'hA3, 8'h66, 8'hA0, 8'h55};
    compare_log("rr_after_single");

    // Round robin, requester 0 still holding a second burst
    do_reset();
    for (int i = 0; i < NREQ; i++) push(i, 8'h10 + 8'(i), 1);
    push(0, 8'h20, 1);
    run(24);
    exp_q = '{8'hA0, 8'h10, 8'hA1, 8'h11, 8'hA2, 8'h12, 8'hA3, 8'h13, 8'hA0, 8'h20};
    compare_log("round_robin");

    // Backpressure mid-burst
    for (int b = 0; b < 4; b++) push(1, 8'h31 + 8'(b), b == 3);
    run(3);
    tx_full = 1'b1;
    quiet_viol = 0;
    run(5);
    check("bp_quiet", quiet_viol, 0);
    tx_full = 1'b0;
    run(10);
    exp_q = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'h34};
    compare_log("backpressure");

    // Burst limit forces release and re-arbitration of the same requester
    for (int b = 0; b < 6; b++) push(1, 8'h40 + 8'(b), b == 5);
    run(16);
    exp_q = '{8'hA1, 8'h40, 8'h41, 8'h42, 8'h43, 8'hA1, 8'h44, 8'h45};
    compare_log("burst_limit");

    // Abandon after two payload bytes; requester 3 arrives mid-burst
    ack_cnt[0] = 0; abandon_at[0] = 2;
    for (int b = 0; b < 4; b++) push(0, 8'h50 + 8'(b), 0);
    run(3);
    push(3, 8'h60, 1);
    run(12);
    abandon_at[0] = -1;
    exp_q = '{8'hA0, 8'h50, 8'h51, 8'hA3, 8'h60};
    compare_log("abandon");

    // Asynchronous reset during DATA
    for (int b = 0; b < 4; b++) push(2, 8'h71 + 8'(b), 0);
    run(3);
    reset = 1'b0;
    #1;
    check("arst_twr_en", twr_en, 1'b0);
    check("arst_ack", ack, '0);
    check("arst_busy", busy, 1'b0);
    check("arst_twr_data", twr_data, 8'h00);
    check("arst_gnt_id", gnt_id, 4'h0);
    wr_log.delete();
    do_reset();
    push(3, 8'h81, 1); push(0, 8'h82, 1);
    run(12);
    exp_q = '{8'hA0, 8'h82, 8'hA3, 8'h81};
    compare_log("after_reset");

    // Randomized traffic with backpressure and abandonment
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (head[i] == tail[i] && $urandom_range(0, 7) == 0) begin
          int len;
          bit never_last;
          flush(i);
          len        = $urandom_range(1, 7);
          never_last = ($urandom_range(0, 3) == 0);
          for (int b = 0; b < len; b++)
            push(i, 8'($urandom), !never_last && b == len - 1);
        end
      end
      if ($urandom_range(0, 39) == 0) flush($urandom_range(0, NREQ - 1));
      tx_full = ($urandom_range(0, 3) == 0);
      step();
    end
    wr_log.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and burst sequencer that shares the single UART transmit-FIFO write port (twr_en/twr_data/tx_full) among NREQ requesters.
- Each grant emits one header byte that identifies the requester, followed by a burst of payload bytes.
- A burst ends on the requester's last byte, on the MAX_BURST limit, or when the requester abandons it.
- Sits between on-chip byte sources and the uart block's transmit side.

Parameters:
- NREQ, 4, number of requesters (2..16).
- NBITS, 8, data width; must match the uart data width.
- MAX_BURST, 16, maximum payload bytes per grant (1..255).
- HDR_EN, 1, 1 = send a header byte before each burst; 0 = no header.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  per-requester request; held high while data is valid.
- req_data  in  NREQ*NBITS  flattened payload; requester i uses bits [i*NBITS +: NBITS].
- req_last  in  NREQ  marks the current byte of requester i as the last byte of its burst.
- ack  out  NREQ  one-hot; byte of requester i consumed this cycle.
- tx_full  in  1  uart transmit FIFO full.
- twr_en  out  1  transmit FIFO write enable.
- twr_data  out  NBITS  transmit FIFO write data.
- busy  out  1  a grant is active (state not IDLE).
- gnt_id  out  4  id of the current or most recent grant.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, gnt_id=0, byte count=0.
  - busy=0, twr_en=0, twr_data=0, ack=0.
- Timing: state, rr_ptr, gnt_id and count are registered. twr_en, twr_data and ack are combinational from state, gnt_id, req, req_data, req_last and tx_full.
- A FIFO write occurs on any rising edge where twr_en=1. twr_en is never asserted while tx_full=1.
- IDLE:
  - twr_en=0, ack=0.
  - If any req bit is set, grant the first set bit searching from rr_ptr upward, modulo NREQ.
  - Register the grant in gnt_id, clear count, go to HDR (HDR_EN=1) or DATA (HDR_EN=0).
  - If no req bit is set, stay in IDLE.
- HDR:
  - twr_data = 8'hA0 | gnt_id.
  - twr_en = !tx_full. When twr_en=1, go to DATA; otherwise stall in HDR.
  - The header is sent even if req[g] drops during HDR.
- DATA (g = gnt_id):
  - If req[g]=1 and tx_full=0: twr_en=1, twr_data=req_data[g], ack[g]=1, count increments.
  - Go to IDLE if req_last[g]=1 or count+1 == MAX_BURST; otherwise stay.
  - If req[g]=1 and tx_full=1: stall, no ack.
  - If req[g]=0: burst is abandoned, go to IDLE with no write.
- rr_ptr update: on every DATA to IDLE transition, rr_ptr = (g+1) mod NREQ. A granted requester therefore has lowest priority in the next arbitration.
- Latency: req rising in cycle 0 with tx_full=0 and HDR_EN=1:
  - header is written at edge 2;
  - first ack and payload write occur in cycle 2.
  - With HDR_EN=0, the first ack occurs in cycle 1.
- Throughput: one payload byte per cycle while tx_full=0.
- Minimum turnaround: one IDLE cycle between bursts.
- Simultaneous requests: resolved only in IDLE. Requests that arrive during a burst wait; there is no pre-emption.
- MAX_BURST forced release: a requester still holding req re-arbitrates on the normal round-robin schedule.
- ack and twr_en are always coincident and one-hot consistent (ack[g] only when twr_en is from DATA).
- Reset mid-burst: immediate return to IDLE with all outputs 0. A partially sent burst is not resumed.
- count width is clog2(MAX_BURST+1). gnt_id is zero-extended to 4 bits.

Test Plan:
- Single burst: NREQ=4, HDR_EN=1. req[2]=1 with bytes 8'h11, 8'h22, 8'h33, last on 8'h33 -> FIFO sees A2, 11, 22, 33; ack[2] pulses 3 times; busy falls after the last write; rr_ptr=3.
- Round robin: req=4'b1111, each requester sends one byte with last=1, data 8'h10+i -> FIFO order A0,10,A1,11,A2,12,A3,13, then A0 again if req is still held.
- Backpressure: tx_full=1 for 5 cycles mid-burst -> twr_en=0 and ack=0 throughout; data resumes in the same order with no duplicates or drops.
- Burst limit: MAX_BURST=4, req[1] held with last never set -> exactly A1 plus 4 payload bytes, one IDLE cycle, then a new A1 header if no other request is pending.
- Abandon: req[0] drops after 2 payload bytes -> return to IDLE with no further write; req[3], pending since mid-burst, is granted next with header A3.
- Reset mid-burst: assert reset low during DATA -> twr_en, ack and busy go to 0 asynchronously. After release, the next grant starts at requester 0 (rr_ptr=0) and sends a full header.
